// File: rtl/operand_fetch_stage.sv
// Operand fetch stage: resolves source operands (EX/MEM/WB bypass over regFile data),
// stalls decode on load-use hazards, and registers the result into the ID/EX boundary.
// Optional OPFETCH_STALL_COUNT_EN adds a free-running load-use stall counter output.
module operand_fetch_stage #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_SEL_BITS = 5
) (
    input  logic                    clock,
    input  logic                    reset,
    // Handshake (both sides): a transfer occurs on a rising clock edge where valid and
    // ready are both high; valid may not depend on ready, and payload is stable while valid.
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [REG_SEL_BITS-1:0] rs1,
    input  logic [REG_SEL_BITS-1:0] rs2,
    input  logic                    rs1_used,
    input  logic                    rs2_used,
    input  logic [REG_SEL_BITS-1:0] rd_in,
    input  logic [DATA_WIDTH-1:0]   rf_data1,
    input  logic [DATA_WIDTH-1:0]   rf_data2,
    input  logic                    ex_wen,
    input  logic                    mem_wen,
    input  logic                    wb_wen,
    input  logic [REG_SEL_BITS-1:0] ex_rd,
    input  logic [REG_SEL_BITS-1:0] mem_rd,
    input  logic [REG_SEL_BITS-1:0] wb_rd,
    input  logic [DATA_WIDTH-1:0]   ex_data,
    input  logic [DATA_WIDTH-1:0]   mem_data,
    input  logic [DATA_WIDTH-1:0]   wb_data,
    input  logic                    ex_is_load,
    input  logic                    flush,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [DATA_WIDTH-1:0]   op1,
    output logic [DATA_WIDTH-1:0]   op2,
    output logic [REG_SEL_BITS-1:0] rd_out,
    output logic                    hazard
`ifdef OPFETCH_STALL_COUNT_EN
    ,
    output logic [31:0]             stall_count
`endif
);

    logic                  advance;
    logic                  capture;
    logic [DATA_WIDTH-1:0] op1_next;
    logic [DATA_WIDTH-1:0] op2_next;
    logic                  rs1_load_hit;
    logic                  rs2_load_hit;

    // Register 0 is hard-wired zero and never bypassed. A load still in EX has no data yet,
    // so it is skipped here; the hazard logic stalls instead. The WB path is required
    // because the regFile write lands on the same edge as this read.
    function automatic logic [DATA_WIDTH-1:0] resolve_operand(
        input logic [REG_SEL_BITS-1:0] sel,
        input logic [DATA_WIDTH-1:0]   rf_val,
        input logic                    ex_we,
        input logic                    ex_ld,
        input logic [REG_SEL_BITS-1:0] ex_dst,
        input logic [DATA_WIDTH-1:0]   ex_val,
        input logic                    mem_we,
        input logic [REG_SEL_BITS-1:0] mem_dst,
        input logic [DATA_WIDTH-1:0]   mem_val,
        input logic                    wb_we,
        input logic [REG_SEL_BITS-1:0] wb_dst,
        input logic [DATA_WIDTH-1:0]   wb_val
    );
        logic [DATA_WIDTH-1:0] result;
        result = rf_val;
        if (sel == '0) begin
            result = '0;
        end else if (ex_we && !ex_ld && (ex_dst == sel)) begin
            result = ex_val;
        end else if (mem_we && (mem_dst == sel)) begin
            result = mem_val;
        end else if (wb_we && (wb_dst == sel)) begin
            result = wb_val;
        end
        return result;
    endfunction

    always_comb begin
        op1_next = resolve_operand(rs1, rf_data1, ex_wen, ex_is_load, ex_rd, ex_data,
                                   mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
        op2_next = resolve_operand(rs2, rf_data2, ex_wen, ex_is_load, ex_rd, ex_data,
                                   mem_wen, mem_rd, mem_data, wb_wen, wb_rd, wb_data);
    end

    always_comb begin
        rs1_load_hit = rs1_used && (rs1 == ex_rd);
        rs2_load_hit = rs2_used && (rs2 == ex_rd);
        hazard       = in_valid && ex_wen && ex_is_load && (ex_rd != '0)
                       && (rs1_load_hit || rs2_load_hit);
        advance      = !out_valid || out_ready;
        in_ready     = advance && !hazard && !flush;
        capture      = advance && in_valid && !hazard;
    end

    // Flush outranks everything but reset; a held entry is never re-resolved, so the
    // bypass only matters on the capture edge.
    always_ff @(posedge clock) begin
        if (!reset) begin
            out_valid <= 1'b0;
            op1       <= '0;
            op2       <= '0;
            rd_out    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance) begin
            if (capture) begin
                out_valid <= 1'b1;
                op1       <= op1_next;
                op2       <= op2_next;
                rd_out    <= rd_in;
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef OPFETCH_STALL_COUNT_EN
    // Counts only stalls that actually cost a cycle; a flushed hazard is not a stall.
    always_ff @(posedge clock) begin
        if (!reset) begin
            stall_count <= '0;
        end else if (hazard && !flush) begin
            stall_count <= stall_count + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed scoreboard bench for operand_fetch_stage; stall_count checks are compiled in
// when OPFETCH_STALL_COUNT_EN is defined.
module tb_operand_fetch_stage;

    localparam int DW = 32;
    localparam int RS = 5;
    localparam int EW = RS + 2 * DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic          in_ready;
    logic [RS-1:0] rs1, rs2, rd_in;
    logic          rs1_used, rs2_used;
    logic [DW-1:0] rf_data1, rf_data2;
    logic          ex_wen, mem_wen, wb_wen;
    logic [RS-1:0] ex_rd, mem_rd, wb_rd;
    logic [DW-1:0] ex_data, mem_data, wb_data;
    logic          ex_is_load;
    logic          flush;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] op1, op2;
    logic [RS-1:0] rd_out;
    logic          hazard;
`ifdef OPFETCH_STALL_COUNT_EN
    logic [31:0]   stall_count;
`endif

    logic [EW-1:0] exp_q[$];
    int            n_cmp = 0;
    int            n_err = 0;

    operand_fetch_stage #(.DATA_WIDTH(DW), .REG_SEL_BITS(RS)) dut (
        .clock(clock), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .rs1(rs1), .rs2(rs2), .rs1_used(rs1_used), .rs2_used(rs2_used), .rd_in(rd_in),
        .rf_data1(rf_data1), .rf_data2(rf_data2),
        .ex_wen(ex_wen), .mem_wen(mem_wen), .wb_wen(wb_wen),
        .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
        .ex_data(ex_data), .mem_data(mem_data), .wb_data(wb_data),
        .ex_is_load(ex_is_load), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .op1(op1), .op2(op2), .rd_out(rd_out), .hazard(hazard)
`ifdef OPFETCH_STALL_COUNT_EN
        , .stall_count(stall_count)
`endif
    );

    // ---------------- clock ----------------
    always #5 clock = ~clock;

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clock) begin
        if (reset === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got op1=0x%0h op2=0x%0h rd=%0d expected nothing",
                         op1, op2, rd_out);
            end else begin
                logic [EW-1:0] e;
                e = exp_q.pop_front();
                check("sb_rd",  {59'd0, rd_out}, {59'd0, e[EW-1 -: RS]});
                check("sb_op1", {32'd0, op1},    {32'd0, e[2*DW-1 -: DW]});
                check("sb_op2", {32'd0, op2},    {32'd0, e[DW-1:0]});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_bypass();
        ex_wen = 0; mem_wen = 0; wb_wen = 0; ex_is_load = 0;
        ex_rd = 0; mem_rd = 0; wb_rd = 0;
        ex_data = 0; mem_data = 0; wb_data = 0;
    endtask

    // Drives one instruction (called #1 after a posedge); it is accepted on the next edge.
    task automatic issue(input logic [RS-1:0] s1, input logic [RS-1:0] s2,
                         input logic u1, input logic u2, input logic [RS-1:0] d,
                         input logic [DW-1:0] r1, input logic [DW-1:0] r2,
                         input logic [DW-1:0] e1, input logic [DW-1:0] e2, input bit push);
        in_valid = 1; rs1 = s1; rs2 = s2; rs1_used = u1; rs2_used = u2; rd_in = d;
        rf_data1 = r1; rf_data2 = r2;
        if (push) exp_q.push_back({d, e1, e2});
        @(negedge clock);
        check("in_ready_accept", {63'd0, in_ready}, 64'd1);
        @(posedge clock);
        #1;
        in_valid = 0;
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        n_err++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin
        reset = 0; flush = 0; out_ready = 1;
        clear_bypass();
        in_valid = 1; rs1 = 3; rs2 = 0; rs1_used = 1; rs2_used = 0; rd_in = 1;
        rf_data1 = 32'h11; rf_data2 = 32'h99;

        // Reset held two cycles with in_valid high
        repeat (2) @(posedge clock);
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_op1", {32'd0, op1}, 64'd0);
        check("reset_op2", {32'd0, op2}, 64'd0);
        check("reset_rd_out", {59'd0, rd_out}, 64'd0);
        reset = 1;

        // First instruction after reset; rs2=0 reads as zero regardless of rf_data2
        issue(5'd3, 5'd0, 1, 1, 5'd1, 32'h11, 32'h99, 32'h11, 32'h0, 1);
        check("first_out_valid", {63'd0, out_valid}, 64'd1);

        // Bypass priority EX > MEM > WB > regFile
        ex_wen = 1;  ex_rd = 5;  ex_data = 32'hAA;
        mem_wen = 1; mem_rd = 5; mem_data = 32'hBB;
        wb_wen = 1;  wb_rd = 5;  wb_data = 32'hCC;
        issue(5'd5, 5'd6, 1, 1, 5'd2, 32'hDD, 32'h66, 32'hAA, 32'h66, 1);
        ex_wen = 0;
        issue(5'd5, 5'd6, 1, 1, 5'd2, 32'hDD, 32'h66, 32'hBB, 32'h66, 1);
        mem_wen = 0;
        issue(5'd5, 5'd5, 1, 1, 5'd2, 32'hDD, 32'hD5, 32'hCC, 32'hCC, 1);
        wb_wen = 0;
        issue(5'd5, 5'd6, 1, 1, 5'd2, 32'hDD, 32'h66, 32'hDD, 32'h66, 1);

        // Register 0 is never bypassed
        clear_bypass();
        ex_wen = 1; ex_rd = 0; ex_data = 32'h55;
        issue(5'd2, 5'd0, 1, 1, 5'd4, 32'h22, 32'h77, 32'h22, 32'h0, 1);

        // Unused rs2 matching a load in EX: no hazard, regFile value used
        clear_bypass();
        ex_wen = 1; ex_is_load = 1; ex_rd = 9; ex_data = 32'hBAD;
        in_valid = 1; rs1 = 1; rs2 = 9; rs1_used = 1; rs2_used = 0;
        #1;
        check("unused_no_hazard", {63'd0, hazard}, 64'd0);
        issue(5'd1, 5'd9, 1, 0, 5'd5, 32'h10, 32'h77, 32'h10, 32'h77, 1);

        // Load-use: one bubble, then MEM bypass supplies the loaded value
        clear_bypass();
        ex_wen = 1; ex_is_load = 1; ex_rd = 7; ex_data = 32'hBAD;
        in_valid = 1; rs1 = 7; rs2 = 0; rs1_used = 1; rs2_used = 0; rd_in = 6;
        rf_data1 = 32'hDEAD; rf_data2 = 0;
        @(negedge clock);
        check("loaduse_hazard", {63'd0, hazard}, 64'd1);
        check("loaduse_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clock);
        #1;
        check("loaduse_bubble", {63'd0, out_valid}, 64'd0);
        clear_bypass();
        mem_wen = 1; mem_rd = 7; mem_data = 32'h1234;
        issue(5'd7, 5'd0, 1, 0, 5'd6, 32'hDEAD, 32'h0, 32'h1234, 32'h0, 1);
`ifdef OPFETCH_STALL_COUNT_EN
        check("stall_count_one", stall_count, 64'd1);
`endif

        // Downstream backpressure: held entry stays put while bypass inputs change
        clear_bypass();
        issue(5'd4, 5'd8, 1, 1, 5'd10, 32'h44, 32'h88, 32'h44, 32'h88, 1);
        out_ready = 0;
        in_valid = 1; rs1 = 4; rs2 = 8; rd_in = 11; rf_data1 = 32'h4; rf_data2 = 32'h8;
        for (int i = 0; i < 3; i++) begin
            ex_wen = 1; ex_rd = 4; ex_data = 32'hF0 + i;
            mem_wen = 1; mem_rd = 8; mem_data = 32'hE0 + i;
            @(negedge clock);
            check("hold_out_valid", {63'd0, out_valid}, 64'd1);
            check("hold_op1", {32'd0, op1}, 64'h44);
            check("hold_op2", {32'd0, op2}, 64'h88);
            check("hold_rd_out", {59'd0, rd_out}, 64'd10);
            check("hold_in_ready", {63'd0, in_ready}, 64'd0);
            @(posedge clock);
            #1;
        end
        ex_data = 32'hFF; mem_data = 32'hEE;
        out_ready = 1;
        issue(5'd4, 5'd8, 1, 1, 5'd11, 32'h4, 32'h8, 32'hFF, 32'hEE, 1);

        // Flush together with a hazard while an entry is held
        clear_bypass();
        issue(5'd1, 5'd2, 1, 1, 5'd3, 32'h31, 32'h32, 32'h31, 32'h32, 0);
        out_ready = 0;
        flush = 1;
        ex_wen = 1; ex_is_load = 1; ex_rd = 7;
        in_valid = 1; rs1 = 7; rs1_used = 1; rd_in = 12;
        @(negedge clock);
        check("flush_hazard", {63'd0, hazard}, 64'd1);
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        @(posedge clock);
        #1;
        flush = 0; in_valid = 0; out_ready = 1;
        clear_bypass();
        check("flush_out_valid", {63'd0, out_valid}, 64'd0);
`ifdef OPFETCH_STALL_COUNT_EN
        check("flush_stall_count", stall_count, 64'd1);
`endif

        // Drain
        repeat (3) @(posedge clock);
        #1;
        check("queue_empty", {32'd0, exp_q.size()}, 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Pipeline stage directly downstream of the register file in the 5-stage stall/bypass core.
- Takes the decoded instruction plus the combinational regFile read data, and resolves operands by bypassing from EX, MEM and WB.
- Detects load-use hazards and stalls decode.
- Registers the resolved operands into the ID/EX boundary with a valid/ready handshake, plus flush support.

Parameters:
- DATA_WIDTH, 32, operand/result width.
- REG_SEL_BITS, 5, register index width.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage can accept (combinational).
- rs1, rs2  in  REG_SEL_BITS  source indices; also drive regFile read_sel1/read_sel2.
- rs1_used, rs2_used  in  1  instruction actually reads rs1/rs2.
- rd_in  in  REG_SEL_BITS  destination index, passed through.
- rf_data1, rf_data2  in  DATA_WIDTH  regFile read_data1/read_data2.
- ex_wen, mem_wen, wb_wen  in  1  stage will write a register.
- ex_rd, mem_rd, wb_rd  in  REG_SEL_BITS  destination of EX/MEM/WB.
- ex_data, mem_data, wb_data  in  DATA_WIDTH  result of each stage.
- ex_is_load  in  1  EX instruction is a load (ex_data not yet valid).
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  operands valid for EX.
- out_ready  in  1  EX accepts.
- op1, op2  out  DATA_WIDTH  resolved operands (registered).
- rd_out  out  REG_SEL_BITS  registered destination.
- hazard  out  1  load-use stall this cycle (combinational).

Behaviour:
- Operand select, per source (combinational):
  - Index 0 yields 0 and is never bypassed.
  - Otherwise priority is EX (ex_wen, rd match, !ex_is_load), then MEM, then WB, then rf_data.
  - The WB bypass is mandatory: regFile writes at the clock edge, so the same-cycle read returns the stale value.
- hazard = in_valid & ex_wen & ex_is_load & ex_rd≠0 & ((rs1_used & rs1==ex_rd) | (rs2_used & rs2==ex_rd)).
- advance = !out_valid | out_ready.
- in_ready = advance & !hazard & !flush.
- Register update, in priority order:
  - !reset: out_valid=0, op1=op2=0, rd_out=0.
  - flush: out_valid=0; data registers are don't-care but are held.
  - advance & in_valid & !hazard: capture op1/op2/rd_out, out_valid=1.
  - advance & hazard: out_valid=0 (bubble inserted); decode holds its instruction.
  - advance & !in_valid: out_valid=0.
  - !advance: all registers hold. Operands of a held entry are not re-resolved; bypass applies only at capture.
- Latency: 1 cycle from accept to out_valid.
- Throughput: 1 instruction/cycle with no hazard.
- A load-use stall costs exactly one bubble: the next cycle the load is in MEM and the MEM bypass resolves the operand.
- Simultaneous flush and hazard: flush wins, hazard is asserted but ignored, in_ready=0.
- Reset mid-operation: the valid entry is discarded and the stage accepts in the first cycle after reset deasserts.
- All three bypass sources matching the same rd: EX wins.

Optional Feature:
- Macro OPFETCH_STALL_COUNT_EN.
- When defined, adds output stall_count [31:0]:
  - Increments by 1 each cycle where hazard=1 and flush=0.
  - Cleared by reset; wraps 0xFFFFFFFF→0.
- When undefined, the port and counter are absent; all other behaviour is identical.

Test Plan:
- Reset low for 2 cycles with in_valid=1 → out_valid=0, op1=op2=0. After reset releases, rs1=3 with rf_data1=0x11 → next cycle op1=0x11, out_valid=1.
- rs1=5 with EX(5,0xAA), MEM(5,0xBB), WB(5,0xCC), rf=0xDD → op1=0xAA. Drop EX → 0xBB. Drop MEM → 0xCC. Drop WB → 0xDD.
- rs2=0 with ex_wen, ex_rd=0, ex_data=0x55 → op2=0. rs2_used=0 with ex_is_load and ex_rd=rs2 → no hazard.
- Load-use (ex_is_load, ex_rd=7, rs1=7, rs1_used) → hazard=1, in_ready=0, one bubble. Next cycle MEM(7,0x1234) → op1=0x1234. With OPFETCH_STALL_COUNT_EN defined, stall_count=1.
- out_ready=0 for 3 cycles with out_valid=1 → op1/op2/rd_out stable, in_ready=0. Bypass inputs changing during the hold do not alter outputs.
- flush asserted with hazard=1 and out_valid=1 → next cycle out_valid=0, in_ready=0 during flush, stall_count unchanged.
